phase_xform: RTL and testbench
==============================

Name: phase_xform

Overview:
- Registered data transformer driven by a programmable phase sequencer.
- Each accepted input beat is transformed according to the mode programmed for the current phase, then registered to the output.
- The phase advances per accepted beat and wraps at a programmable last phase.
- Generalises the fixed "pass on state 1, invert otherwise" path: width, phase count and per-phase mode/key are configurable, with valid/ready flow control.

Parameters:
- WIDTH, 32, data width in bits (>=2, power of 2 for rotate mode).
- NPHASE, 8, number of phase table entries (power of 2, >=2); PW = $clog2(NPHASE).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- cfg_we  in  1  write one phase table entry
- cfg_idx  in  PW  table index for cfg_we
- cfg_mode  in  2  mode to write (see package)
- cfg_key  in  WIDTH  key to write
- last_we  in  1  write the wrap point
- last_val  in  PW  new last phase
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_data  in  WIDTH  input data
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_data  out  WIDTH  transformed data
- out_phase  out  PW  phase used for out_data
- cur_phase  out  PW  phase the next accepted beat will use

Behaviour:
- Reset rst, synchronous, active-high; clock clk. All state updates on posedge clk.
- Reset values:
  - out_valid=0, out_data=0, out_phase=0, cur_phase=0, last=NPHASE-1.
  - Table: entry 1 mode=PASS, all other entries mode=INV, all keys=0.
- Modes, applied combinationally to in_data:
  - PASS (0): data unchanged.
  - INV (1): ~data.
  - XOR (2): data ^ key.
  - ROTL (3): rotate left by key[$clog2(WIDTH)-1:0]; an amount of 0 is a pass.
- Handshake:
  - in_ready = !out_valid || out_ready (single output register, no skid buffer).
  - Accept = in_valid && in_ready.
  - On accept: out_data <= xform(in_data, table[cur_phase]); out_phase <= cur_phase; out_valid <= 1.
  - If there is no accept and out_ready is high: out_valid <= 0.
  - out_data and out_phase hold while out_valid && !out_ready.
- Latency: one cycle from accept to out_valid. Full throughput of 1 beat/cycle when out_ready stays high.
- Phase advance, on accept only: cur_phase <= (cur_phase >= last) ? 0 : cur_phase+1.
  - No advance on idle or stalled cycles.
- Table write:
  - The written entry takes effect the cycle after cfg_we.
  - A beat accepted in the same cycle as a write to the same index uses the old entry.
- Wrap write:
  - last <= last_val, effective next cycle.
  - If cur_phase > new last, the next accept still uses cur_phase, then wraps to 0.
  - A last_we in the same cycle as an accept uses the old last for that cycle's advance.
- Indices of 0..NPHASE-1 are always legal, so there is no out-of-range case.
- Reset mid-operation:
  - Any held output is dropped (out_valid=0) and cur_phase returns to 0.
  - Table and last are restored to their reset values.
  - cfg_we and last_we are ignored while rst=1.
- While out_valid=1, out_data/out_phase must not change until the beat is consumed (assertion).

Decomposition:
- Package phase_xform_pkg:
  - mode_t enum (MODE_PASS=0, MODE_INV=1, MODE_XOR=2, MODE_ROTL=3).
  - Reset-table constant function (entry 1 PASS, others INV).
- Sub-module phase_xform_alu:
  - Purely combinational (data, mode, key) -> result, parameterised by WIDTH.
  - Instantiated once.
- The top level holds the table, the phase counter and the output register.

Test Plan:
- Reset then stream 10 beats of A=32'h1234_5678 with out_ready=1:
  - out_data sequence is EDCB_A987, 1234_5678, then EDCB_A987 x6, then EDCB_A987, 1234_5678 (phases 0..7,0,1).
  - Each out_valid appears 1 cycle after its accept.
- Program entry 0 XOR key=FFFF_0000 and entry 2 ROTL key=4; set last=2; send 4 beats of 0000_00F1:
  - Outputs are FFFF_00F1, 0000_00F1, 0000_0F10, FFFF_00F1 with out_phase 0,1,2,0.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1:
  - in_ready=0, out_data held, cur_phase frozen.
  - On release, beats resume with no loss or duplication and phases stay contiguous.
- In the same cycle, accept a beat at phase 3 and write cfg_idx=3 PASS:
  - That beat is inverted.
  - The next visit to phase 3 passes data unchanged.
- With cur_phase=5, write last=2, then accept 2 beats:
  - The beats use phases 5 and 0.
- Assert rst while out_valid=1 and out_ready=0:
  - The next cycle has out_valid=0, out_data=0, cur_phase=0, and table entry 0 back to INV.

Source files
------------

// File: rtl/phase_xform_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | phase_xform_pkg : transform modes and reset phase-table contents     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package phase_xform_pkg;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_INV  = 2'd1,
    MODE_XOR  = 2'd2,
    MODE_ROTL = 2'd3
  } mode_t;

  // Entry 1 passes, every other entry inverts: the legacy behaviour.
  function automatic mode_t reset_mode(input int idx);
    return (idx == 1) ? MODE_PASS : MODE_INV;
  endfunction

endpackage
`default_nettype wire

// File: rtl/phase_xform_alu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | phase_xform_alu : combinational data transform selected by mode      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module phase_xform_alu
  import phase_xform_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] data,
  input  mode_t            mode,
  input  logic [WIDTH-1:0] key,
  output logic [WIDTH-1:0] result
);

  localparam int SW = $clog2(WIDTH);

  logic [SW-1:0]    rot_amt;
  logic [WIDTH-1:0] rot_data;

  assign rot_amt = key[SW-1:0];
  // A right shift by the full width yields zero, so an amount of 0 falls out as a pass.
  assign rot_data = (data << rot_amt) | (data >> (WIDTH - int'(rot_amt)));

  always_comb begin
    result = data;
    case (mode)
      MODE_PASS: result = data;
      MODE_INV:  result = ~data;
      MODE_XOR:  result = data ^ key;
      MODE_ROTL: result = rot_data;
      default:   result = data;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/phase_xform.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | phase_xform : phase-sequenced registered data transformer            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module phase_xform
  import phase_xform_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int NPHASE = 8,
  localparam int PW     = $clog2(NPHASE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [PW-1:0]    cfg_idx,
  input  logic [1:0]       cfg_mode,
  input  logic [WIDTH-1:0] cfg_key,
  input  logic             last_we,
  input  logic [PW-1:0]    last_val,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [PW-1:0]    out_phase,
  output logic [PW-1:0]    cur_phase
);

  mode_t            mode_tab [NPHASE];
  logic [WIDTH-1:0] key_tab  [NPHASE];
  logic [PW-1:0]    last_phase;
  logic             accept;
  logic [WIDTH-1:0] xform_data;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  phase_xform_alu #(.WIDTH(WIDTH)) u_alu (
    .data   (in_data),
    .mode   (mode_tab[cur_phase]),
    .key    (key_tab[cur_phase]),
    .result (xform_data)
  );

  // Table and wrap point: writes land at the edge, so a same-cycle beat sees old values.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NPHASE; i++) begin
        mode_tab[i] <= reset_mode(i);
        key_tab[i]  <= '0;
      end
      last_phase <= PW'(NPHASE - 1);
    end else begin
      if (cfg_we) begin
        mode_tab[cfg_idx] <= mode_t'(cfg_mode);
        key_tab[cfg_idx]  <= cfg_key;
      end
      if (last_we) last_phase <= last_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_phase <= '0;
      cur_phase <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= xform_data;
      out_phase <= cur_phase;
      // >= so a phase stranded beyond a lowered wrap point still returns to 0.
      cur_phase <= (cur_phase >= last_phase) ? '0 : cur_phase + PW'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  a_hold_stalled : assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_phase)));

endmodule
`default_nettype wire

// File: tb/tb_phase_xform.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_phase_xform : directed and random checks against a table model    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_phase_xform;

  localparam int W  = 32;
  localparam int N  = 8;
  localparam int PW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_we;
  logic [PW-1:0] cfg_idx;
  logic [1:0]    cfg_mode;
  logic [W-1:0]  cfg_key;
  logic          last_we;
  logic [PW-1:0] last_val;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [PW-1:0] out_phase;
  logic [PW-1:0] cur_phase;

  int tests = 0;
  int fails = 0;

  logic [1:0]   m_mode [N];
  logic [W-1:0] m_key  [N];
  int           m_last, m_cur, m_ophase;
  logic         m_valid;
  logic [W-1:0] m_data;

  logic [W-1:0] exp_a [10] = '{32'hEDCB_A987, 32'h1234_5678,
                               32'hEDCB_A987, 32'hEDCB_A987, 32'hEDCB_A987,
                               32'hEDCB_A987, 32'hEDCB_A987, 32'hEDCB_A987,
                               32'hEDCB_A987, 32'h1234_5678};
  logic [W-1:0] exp_b [4]  = '{32'hFFFF_00F1, 32'h0000_00F1, 32'h0000_0F10, 32'hFFFF_00F1};
  int           exp_bp[4]  = '{0, 1, 2, 0};

  always #5 clk = ~clk;

  phase_xform #(.WIDTH(W), .NPHASE(N)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_mode(cfg_mode), .cfg_key(cfg_key),
    .last_we(last_we), .last_val(last_val),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_phase(out_phase), .cur_phase(cur_phase)
  );

  function automatic logic [W-1:0] ref_xform(input logic [W-1:0] d, input logic [1:0] mode,
                                             input logic [W-1:0] key);
    int k;
    k = int'(key % 32'(W));
    case (mode)
      2'd0:    return d;
      2'd1:    return ~d;
      2'd2:    return d ^ key;
      default: return (k == 0) ? d : ((d << k) | (d >> (W - k)));
    endcase
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid  = 1'b0;
    m_data   = '0;
    m_ophase = 0;
    m_cur    = 0;
    m_last   = N - 1;
    for (int i = 0; i < N; i++) begin
      m_mode[i] = (i == 1) ? 2'd0 : 2'd1;
      m_key[i]  = '0;
    end
  endtask

  // One clock: predict from current inputs, step the clock, compare every output.
  task automatic tick();
    logic acc;
    #1;
    if (!rst) check("in_ready", W'(in_ready), W'(!m_valid || out_ready));
    if (rst) begin
      model_reset();
    end else begin
      acc = in_valid && (!m_valid || out_ready);
      if (acc) begin
        m_data   = ref_xform(in_data, m_mode[m_cur], m_key[m_cur]);
        m_ophase = m_cur;
        m_valid  = 1'b1;
        m_cur    = (m_cur >= m_last) ? 0 : m_cur + 1;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
      if (cfg_we) begin
        m_mode[cfg_idx] = cfg_mode;
        m_key[cfg_idx]  = cfg_key;
      end
      if (last_we) m_last = int'(last_val);
    end
    @(posedge clk);
    #1;
    check("out_valid", W'(out_valid), W'(m_valid));
    check("out_data",  out_data,       m_data);
    check("out_phase", W'(out_phase),  W'(m_ophase));
    check("cur_phase", W'(cur_phase),  W'(m_cur));
  endtask

  task automatic cfg_write(input int idx, input logic [1:0] mode, input logic [W-1:0] key);
    cfg_we = 1'b1; cfg_idx = PW'(idx); cfg_mode = mode; cfg_key = key;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_mode = '0; cfg_key = '0;
    last_we = 1'b0; last_val = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    model_reset();
    @(posedge clk); #1;
    tick();
    check("reset_valid", W'(out_valid), W'(0));
    check("reset_phase", W'(cur_phase), W'(0));
    rst = 1'b0;

    // Default table over 10 beats: phases 0..7,0,1.
    in_valid = 1'b1; in_data = 32'h1234_5678;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("seq_a%0d", i), out_data, exp_a[i]);
    end
    in_valid = 1'b0;
    tick();

    // XOR on 0, ROTL by 4 on 2, wrap at 2.
    do_reset();
    cfg_write(0, 2'd2, 32'hFFFF_0000);
    cfg_write(2, 2'd3, 32'd4);
    last_we = 1'b1; last_val = 3'd2; tick(); last_we = 1'b0;
    in_valid = 1'b1; in_data = 32'h0000_00F1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("cfg_data%0d", i), out_data, exp_b[i]);
      check($sformatf("cfg_phase%0d", i), W'(out_phase), W'(exp_bp[i]));
    end

    // Backpressure: hold three cycles, then resume with contiguous phases.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_in_ready", W'(in_ready), W'(0));
      check("bp_hold", out_data, 32'hFFFF_00F1);
      check("bp_frozen", W'(cur_phase), W'(1));
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("bp_resume%0d", i), W'(out_phase), W'((i + 1) % 3));
    end
    in_valid = 1'b0;
    tick();

    // Same-cycle write to the phase being used: old entry applies.
    do_reset();
    in_valid = 1'b1; in_data = 32'h1234_5678;
    for (int i = 0; i < 3; i++) tick();
    cfg_we = 1'b1; cfg_idx = 3'd3; cfg_mode = 2'd0; cfg_key = '0;
    tick();
    cfg_we = 1'b0;
    check("wr_same_cycle", out_data, 32'hEDCB_A987);
    for (int i = 0; i < 8; i++) tick();
    check("wr_next_visit_phase", W'(out_phase), W'(3));
    check("wr_next_visit", out_data, 32'h1234_5678);

    // Lower wrap point below the current phase (now 4).
    tick();
    check("wrap_cur5", W'(cur_phase), W'(5));
    in_valid = 1'b0; last_we = 1'b1; last_val = 3'd2;
    tick();
    last_we = 1'b0; in_valid = 1'b1;
    tick();
    check("wrap_beat0", W'(out_phase), W'(5));
    tick();
    check("wrap_beat1", W'(out_phase), W'(0));

    // Reset while a beat is held.
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_valid", W'(out_valid), W'(0));
    check("rst_data", out_data, 32'h0);
    check("rst_cur", W'(cur_phase), W'(0));
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h0F0F_1234;
    tick();
    in_valid = 1'b0;
    check("rst_entry0_inv", out_data, 32'hF0F0_EDCB);

    // Random traffic, configuration and resets against the model.
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 79) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data   = $urandom;
      cfg_we    = ($urandom_range(0, 5) == 0);
      cfg_idx   = PW'($urandom_range(0, N - 1));
      cfg_mode  = 2'($urandom_range(0, 3));
      cfg_key   = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 40)) : W'($urandom);
      last_we   = ($urandom_range(0, 11) == 0);
      last_val  = PW'($urandom_range(0, N - 1));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
